// File: rtl/bsg_wormhole_packet_injector_if.sv
// Request, body-word and router-link handshakes of the wormhole packet injector.
// Signal suffixes are from the injector's point of view.
interface bsg_wormhole_packet_injector_if #(
   parameter int unsigned flit_width_p = 32,
   parameter int unsigned cord_width_p = 8,
   parameter int unsigned len_width_p  = 4
);
   localparam int unsigned user_width_lp = flit_width_p - cord_width_p - len_width_p;

   logic                     v_i;
   logic                     ready_and_o;
   logic [cord_width_p-1:0]  dest_cord_i;
   logic [len_width_p-1:0]   len_i;
   logic [user_width_lp-1:0] hdr_user_i;
   logic                     data_v_i;
   logic [flit_width_p-1:0]  data_i;
   logic                     data_ready_and_o;
   logic                     link_v_o;
   logic [flit_width_p-1:0]  link_data_o;
   logic                     link_ready_and_i;

   modport slave (
      input  v_i, dest_cord_i, len_i, hdr_user_i, data_v_i, data_i, link_ready_and_i,
      output ready_and_o, data_ready_and_o, link_v_o, link_data_o
   );

   modport master (
      output v_i, dest_cord_i, len_i, hdr_user_i, data_v_i, data_i, link_ready_and_i,
      input  ready_and_o, data_ready_and_o, link_v_o, link_data_o
   );
endinterface

// File: rtl/bsg_wormhole_packet_injector.sv
// Formats {user,len,cord} header plus len body flits onto a router P-port link
// through a 2-entry registered buffer, and counts fully delivered packets.
module bsg_wormhole_packet_injector #(
   parameter int unsigned flit_width_p = 32,
   parameter int unsigned cord_width_p = 8,
   parameter int unsigned len_width_p  = 4,
   parameter int unsigned cnt_width_p  = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   bsg_wormhole_packet_injector_if.slave io,
   output logic                   busy_o,
   output logic [cnt_width_p-1:0] pkts_sent_o
);
   localparam int unsigned user_width_lp = flit_width_p - cord_width_p - len_width_p;

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

   typedef struct packed {
      logic                    last;
      logic [flit_width_p-1:0] flit;
   } entry_s;

   state_e                   state_q, state_d;
   logic                     ready_q, ready_d;
   logic [cord_width_p-1:0]  cord_q, cord_d;
   logic [len_width_p-1:0]   len_q, len_d;
   logic [user_width_lp-1:0] user_q, user_d;
   logic [len_width_p-1:0]   rem_q, rem_d;

   entry_s                   mem_q [2];
   logic                     wr_ptr_q, rd_ptr_q;
   logic [1:0]               cnt_q;
   logic [cnt_width_p-1:0]   pkts_q;

   logic                     full, empty, push, pop;
   entry_s                   push_entry;

   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);
   assign pop   = !empty && io.link_ready_and_i;

   assign io.ready_and_o      = ready_q;
   assign io.data_ready_and_o = (state_q == BODY) && !full;
   assign io.link_v_o         = !empty;
   assign io.link_data_o      = mem_q[rd_ptr_q].flit;
   assign busy_o              = (state_q != IDLE) || !empty;
   assign pkts_sent_o         = pkts_q;

   // Next-state, field latching and buffer push selection
   always_comb begin
      state_d    = state_q;
      cord_d     = cord_q;
      len_d      = len_q;
      user_d     = user_q;
      rem_d      = rem_q;
      push       = 1'b0;
      push_entry = '0;
      unique case (state_q)
         IDLE: begin
            if (io.v_i && ready_q) begin
               cord_d  = io.dest_cord_i;
               len_d   = io.len_i;
               user_d  = io.hdr_user_i;
               state_d = HDR;
            end
         end
         HDR: begin
            if (!full) begin
               push            = 1'b1;
               push_entry.flit = {user_q, len_q, cord_q};
               push_entry.last = (len_q == '0);
               rem_d           = len_q;
               state_d         = (len_q == '0) ? IDLE : BODY;
            end
         end
         BODY: begin
            if (io.data_v_i && !full) begin
               push            = 1'b1;
               push_entry.flit = io.data_i;
               push_entry.last = (rem_q == len_width_p'(1));
               rem_d           = rem_q - len_width_p'(1);
               if (rem_q == len_width_p'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered so the request port stays closed while reset is held
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         cord_q  <= '0;
         len_q   <= '0;
         user_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         cord_q  <= cord_d;
         len_q   <= len_d;
         user_q  <= user_d;
         rem_q   <= rem_d;
      end
   end

   // Output buffer; push is gated by !full so depth never exceeds 2
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)                     pkts_q <= '0;
      else if (pop && mem_q[rd_ptr_q].last) pkts_q <= pkts_q + cnt_width_p'(1);
   end
endmodule

// File: tb/tb_bsg_wormhole_packet_injector.sv
// Directed bench for the wormhole packet injector; the link monitor stands in for the router.
module tb_bsg_wormhole_packet_injector;
   localparam int unsigned FW = 32;
   localparam int unsigned CW = 8;
   localparam int unsigned LW = 4;
   localparam int unsigned UW = FW - CW - LW;
   // Narrow counter so the wrap case needs only 256 packets
   localparam int unsigned NW = 8;

   logic clk_i = 1'b0;
   logic reset_ni = 1'b0;
   logic busy_o;
   logic [NW-1:0] pkts_sent_o;

   always #5 clk_i = ~clk_i;

   bsg_wormhole_packet_injector_if #(.flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW)) io ();

   bsg_wormhole_packet_injector #(
      .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW), .cnt_width_p(NW)
   ) dut (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .io         (io),
      .busy_o     (busy_o),
      .pkts_sent_o(pkts_sent_o)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [FW-1:0] rx_q [$];
   logic [FW-1:0] exp_q [$];
   logic [NW-1:0] exp_pkts = '0;
   bit rand_link = 1'b0;
   bit zl_mode = 1'b0;
   logic [FW-1:0] held;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      if (rand_link) io.link_ready_and_i = 1'($urandom_range(0, 1));
   endtask

   task automatic do_req(input logic [CW-1:0] c, input logic [LW-1:0] l,
                         input logic [UW-1:0] u, input bit gaps);
      bit hs = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      io.v_i = 1'b1; io.dest_cord_i = c; io.len_i = l; io.hdr_user_i = u;
      for (int k = 0; k < 1000 && !hs; k++) begin
         @(negedge clk_i);
         hs = io.ready_and_o;
         step();
      end
      io.v_i = 1'b0;
      io.dest_cord_i = CW'($urandom()); io.len_i = LW'($urandom()); io.hdr_user_i = UW'($urandom());
      if (!hs) begin n_cmp++; n_err++; $error("FAIL req_timeout: observed=no_handshake expected=handshake"); end
      exp_q.push_back({u, l, c});
   endtask

   task automatic do_word(input logic [FW-1:0] w, input bit gaps);
      bit hs = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      io.data_v_i = 1'b1; io.data_i = w;
      for (int k = 0; k < 1000 && !hs; k++) begin
         @(negedge clk_i);
         hs = io.data_ready_and_o;
         step();
      end
      io.data_v_i = 1'b0;
      io.data_i = $urandom();
      if (!hs) begin n_cmp++; n_err++; $error("FAIL data_timeout: observed=no_handshake expected=handshake"); end
      exp_q.push_back(w);
   endtask

   task automatic send_pkt(input logic [CW-1:0] c, input logic [LW-1:0] l,
                           input logic [UW-1:0] u, input bit gaps);
      do_req(c, l, u, gaps);
      for (int i = 0; i < int'(l); i++) do_word($urandom(), gaps);
      exp_pkts = exp_pkts + NW'(1);
   endtask

   task automatic drain_and_compare(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk_i);
         done = !busy_o && !io.link_v_o;
         step();
      end
      if (!done) begin n_cmp++; n_err++; $error("FAIL %s_drain: observed=busy expected=idle", tag); end
      check({tag, "_nflits"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_flit%0d", tag, i), rx_q[i], exp_q[i]);
      check({tag, "_pkts"}, 32'(pkts_sent_o), 32'(exp_pkts));
      rx_q.delete();
      exp_q.delete();
   endtask

   // Router side: capture every accepted flit and watch handshake exclusivity
   always @(negedge clk_i) begin
      if (reset_ni) begin
         if (io.link_v_o && io.link_ready_and_i) rx_q.push_back(io.link_data_o);
         if (io.ready_and_o && io.data_ready_and_o)
            check("req_while_body", 32'(io.ready_and_o), 32'(0));
         if (zl_mode) check("zl_data_ready", 32'(io.data_ready_and_o), 32'(0));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      io.v_i = 1'b0; io.dest_cord_i = '0; io.len_i = '0; io.hdr_user_i = '0;
      io.data_v_i = 1'b0; io.data_i = '0; io.link_ready_and_i = 1'b1;
      #2;
      check("rst_link_v", 32'(io.link_v_o), 32'(0));
      check("rst_ready", 32'(io.ready_and_o), 32'(0));
      check("rst_data_ready", 32'(io.data_ready_and_o), 32'(0));
      check("rst_busy", 32'(busy_o), 32'(0));
      check("rst_pkts", 32'(pkts_sent_o), 32'(0));
      @(negedge clk_i); reset_ni = 1'b1;
      step();
      check("ready_after_rst", 32'(io.ready_and_o), 32'(1));

      // Single packet with latency checks
      do_req(8'h05, 4'd2, 20'h0003A, 1'b0);
      check("hdr_t1_link_v", 32'(io.link_v_o), 32'(0));
      step();
      check("hdr_t2_link_v", 32'(io.link_v_o), 32'(1));
      check("hdr_t2_data", io.link_data_o, 32'h0003A205);
      do_word(32'hAAAA0001, 1'b0);
      check("body0", io.link_data_o, 32'hAAAA0001);
      do_word(32'hAAAA0002, 1'b0);
      check("body1", io.link_data_o, 32'hAAAA0002);
      exp_pkts = exp_pkts + NW'(1);
      step();
      check("single_pkts", 32'(pkts_sent_o), 32'(1));
      check("single_link_idle", 32'(io.link_v_o), 32'(0));
      drain_and_compare("single");

      // Zero-length packet
      zl_mode = 1'b1;
      send_pkt(8'h11, 4'd0, 20'h0, 1'b0);
      drain_and_compare("zero_len");
      zl_mode = 1'b0;
      check("zero_len_pkts", 32'(pkts_sent_o), 32'(2));

      // Backpressure
      io.link_ready_and_i = 1'b0;
      fork
         send_pkt(8'h22, 4'd3, 20'h00155, 1'b0);
      join_none
      repeat (6) step();
      check("bp_data_ready", 32'(io.data_ready_and_o), 32'(0));
      check("bp_link_v", 32'(io.link_v_o), 32'(1));
      check("bp_head", io.link_data_o, 32'h00155322);
      held = io.link_data_o;
      repeat (3) step();
      check("bp_head_stable", io.link_data_o, 32'h00155322);
      check("bp_busy", 32'(busy_o), 32'(1));
      io.link_ready_and_i = 1'b1;
      wait fork;
      drain_and_compare("backpressure");

      // Max length and counter wrap
      while (exp_pkts != NW'(255)) send_pkt(CW'($urandom()), 4'd0, UW'($urandom()), 1'b0);
      send_pkt(8'h33, 4'd15, 20'h0BEEF, 1'b0);
      drain_and_compare("maxlen_wrap");
      check("wrap_pkts_zero", 32'(pkts_sent_o), 32'(0));

      // Asynchronous reset mid-packet
      do_req(8'h44, 4'd5, 20'h7, 1'b0);
      do_word(32'h12345678, 1'b0);
      do_word(32'h9ABCDEF0, 1'b0);
      #3 reset_ni = 1'b0;
      #1;
      check("mid_rst_link_v", 32'(io.link_v_o), 32'(0));
      check("mid_rst_busy", 32'(busy_o), 32'(0));
      check("mid_rst_ready", 32'(io.ready_and_o), 32'(0));
      check("mid_rst_pkts", 32'(pkts_sent_o), 32'(0));
      rx_q.delete(); exp_q.delete(); exp_pkts = '0;
      #4 reset_ni = 1'b1;
      step();
      check("mid_rst_ready_back", 32'(io.ready_and_o), 32'(1));
      send_pkt(8'h55, 4'd1, 20'h99, 1'b0);
      drain_and_compare("after_reset");

      // Random stress
      rand_link = 1'b1;
      for (int p = 0; p < 300; p++) send_pkt(CW'($urandom()), LW'($urandom()), UW'($urandom()), 1'b1);
      drain_and_compare("stress");
      rand_link = 1'b0;
      io.link_ready_and_i = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
